// File: rtl/clk_emu_pkg.sv
// -----------------------------------------------------------------------------
// clk_emu_pkg
// Shared definitions for the emulated clock generators.
//   clk_state_t : generator run state (RUNNING / STOPPED)
//   time_t      : emulated-time word at the default width; blocks built with
//                 a different TIME_WIDTH declare logic [TIME_WIDTH-1:0]
//   clamp_inc() : forces a zero phase increment up to 1
// -----------------------------------------------------------------------------
package clk_emu_pkg;

   localparam int unsigned TIME_WIDTH_DEFAULT = 32;

   typedef logic [TIME_WIDTH_DEFAULT-1:0] time_t;

   typedef enum logic [0:0] {
      RUNNING = 1'b0,
      STOPPED = 1'b1
   } clk_state_t;

   // A zero increment would make the generator re-fire on the same emulated
   // time forever, so it is raised to the minimum legal step of 1.
   function automatic logic [63:0] clamp_inc(input logic [63:0] inc);
      if (inc == 64'd0) begin
         clamp_inc = 64'd1;
      end else begin
         clamp_inc = inc;
      end
   endfunction

endpackage

// File: rtl/prog_clock_if.sv
// -----------------------------------------------------------------------------
// prog_clock_if
// Increment-reprogramming channel of prog_clock (valid/ready).
//   cfg_valid  : new increment pair offered        (master -> slave)
//   cfg_ready  : config slot free, registered      (slave  -> master)
//   cfg_hi_inc : new high-phase increment          (master -> slave)
//   cfg_lo_inc : new low-phase increment           (master -> slave)
// -----------------------------------------------------------------------------
interface prog_clock_if #(
   parameter int INC_WIDTH = 16
);
   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [INC_WIDTH-1:0] cfg_hi_inc;
   logic [INC_WIDTH-1:0] cfg_lo_inc;

   modport master (output cfg_valid, output cfg_hi_inc, output cfg_lo_inc,
                   input  cfg_ready);
   modport slave  (input  cfg_valid, input  cfg_hi_inc, input  cfg_lo_inc,
                   output cfg_ready);
endinterface

// File: rtl/prog_clock_cfg.sv
// -----------------------------------------------------------------------------
// prog_clock_cfg
// Increment configuration for prog_clock: one-deep shadow behind a valid/ready
// handshake, zero clamping at load, and hand-over to the active pair on a
// rising-edge event only so the emulated clock never sees a torn period.
//   clk_sys, rst_n : system clock, async active-low reset
//   cfg            : config channel (slave side)
//   rise_evt       : a rising edge fires this cycle
//   hi_use         : high increment to add if a rise fires this cycle
//   lo_use         : active low increment (falls and restart)
// -----------------------------------------------------------------------------
module prog_clock_cfg
   import clk_emu_pkg::*;
#(
   parameter int INC_WIDTH   = 16,
   parameter int HI_INC_INIT = 1,
   parameter int LO_INC_INIT = 1
) (
   input  logic                 clk_sys,
   input  logic                 rst_n,
   prog_clock_if.slave          cfg,
   input  logic                 rise_evt,
   output logic [INC_WIDTH-1:0] hi_use,
   output logic [INC_WIDTH-1:0] lo_use
);

   logic [INC_WIDTH-1:0] active_hi_r;
   logic [INC_WIDTH-1:0] active_lo_r;
   logic [INC_WIDTH-1:0] shadow_hi_r;
   logic [INC_WIDTH-1:0] shadow_lo_r;
   logic                 ready_r;
   logic                 apply_s;

   // A pending pair exists exactly while the slot is not ready; it is taken
   // over on the next rise. A transfer in the rise cycle itself is not pending
   // yet, so that edge still uses the old pair.
   assign apply_s = rise_evt && !ready_r;

   // Shadow load, apply-on-rise and ready flag.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         active_hi_r <= INC_WIDTH'(HI_INC_INIT);
         active_lo_r <= INC_WIDTH'(LO_INC_INIT);
         shadow_hi_r <= INC_WIDTH'(HI_INC_INIT);
         shadow_lo_r <= INC_WIDTH'(LO_INC_INIT);
         ready_r     <= 1'b1;
      end else if (apply_s) begin
         active_hi_r <= shadow_hi_r;
         active_lo_r <= shadow_lo_r;
         ready_r     <= 1'b1;
      end else if (cfg.cfg_valid && ready_r) begin
         shadow_hi_r <= INC_WIDTH'(clamp_inc(64'(cfg.cfg_hi_inc)));
         shadow_lo_r <= INC_WIDTH'(clamp_inc(64'(cfg.cfg_lo_inc)));
         ready_r     <= 1'b0;
      end else begin
         ready_r     <= ready_r;
      end
   end

   // The rise that applies the shadow already steps by the new high increment.
   always_comb begin
      hi_use = active_hi_r;
      if (apply_s) begin
         hi_use = shadow_hi_r;
      end else begin
         hi_use = active_hi_r;
      end
   end

   assign lo_use        = active_lo_r;
   assign cfg.cfg_ready = ready_r;

endmodule

// File: rtl/prog_clock.sv
// -----------------------------------------------------------------------------
// prog_clock
// Runtime-programmable emulated clock generator. Proposes the emulated time of
// its next edge and toggles its level when the global next time matches.
//   clk_sys, rst_n : system clock, async active-low reset
//   time_next      : global next emulated time
//   time_clock     : emulated time of this generator's next edge
//   time_eq        : generator fires this cycle (combinational)
//   clk_out        : emulated clock level, N copies
//   rise, fall     : one-cycle edge pulses
//   run            : level enable, sampled at falling edges
//   cfg            : increment reprogramming channel (slave side)
//   rise_cnt       : rising edge counter (wrapping)
// -----------------------------------------------------------------------------
module prog_clock
   import clk_emu_pkg::*;
#(
   parameter int N           = 1,
   parameter int TIME_WIDTH  = 32,
   parameter int INC_WIDTH   = 16,
   parameter int CNT_WIDTH   = 32,
   parameter int HI_INC_INIT = 1,
   parameter int LO_INC_INIT = 1
) (
   input  logic                  clk_sys,
   input  logic                  rst_n,
   input  logic [TIME_WIDTH-1:0] time_next,
   output logic [TIME_WIDTH-1:0] time_clock,
   output logic                  time_eq,
   output logic [N-1:0]          clk_out,
   output logic                  rise,
   output logic                  fall,
   input  logic                  run,
   prog_clock_if.slave           cfg,
   output logic [CNT_WIDTH-1:0]  rise_cnt
);

   clk_state_t            state_r;
   clk_state_t            state_nxt_s;
   logic                  level_r;
   logic [TIME_WIDTH-1:0] time_clock_r;
   logic [TIME_WIDTH-1:0] time_clock_nxt_s;
   logic                  rise_r;
   logic                  fall_r;
   logic [CNT_WIDTH-1:0]  rise_cnt_r;
   logic                  fire_s;
   logic                  rise_evt_s;
   logic                  fall_evt_s;
   logic [INC_WIDTH-1:0]  hi_use_s;
   logic [INC_WIDTH-1:0]  lo_use_s;

   prog_clock_cfg #(
      .INC_WIDTH   (INC_WIDTH),
      .HI_INC_INIT (HI_INC_INIT),
      .LO_INC_INIT (LO_INC_INIT)
   ) u_cfg (
      .clk_sys  (clk_sys),
      .rst_n    (rst_n),
      .cfg      (cfg),
      .rise_evt (rise_evt_s),
      .hi_use   (hi_use_s),
      .lo_use   (lo_use_s)
   );

   // FSM state register.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= RUNNING;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next state: a stop request only bites on a falling edge, so the
   // generator always parks with the level low.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         RUNNING: begin
            if (fall_evt_s && !run) begin
               state_nxt_s = STOPPED;
            end else begin
               state_nxt_s = RUNNING;
            end
         end
         STOPPED: begin
            if (run) begin
               state_nxt_s = RUNNING;
            end else begin
               state_nxt_s = STOPPED;
            end
         end
         default: state_nxt_s = RUNNING;
      endcase
   end

   // FSM outputs: fire decode and edge direction.
   always_comb begin
      fire_s     = 1'b0;
      rise_evt_s = 1'b0;
      fall_evt_s = 1'b0;
      case (state_r)
         RUNNING: begin
            fire_s     = (time_clock_r == time_next);
            rise_evt_s = fire_s && !level_r;
            fall_evt_s = fire_s && level_r;
         end
         STOPPED: begin
            fire_s = 1'b0;
         end
         default: begin
            fire_s = 1'b0;
         end
      endcase
   end

   // Next edge time; additions wrap, which is harmless since only equality
   // against time_next is ever tested.
   always_comb begin
      time_clock_nxt_s = time_clock_r;
      case (state_r)
         RUNNING: begin
            if (rise_evt_s) begin
               time_clock_nxt_s = time_clock_r + TIME_WIDTH'(hi_use_s);
            end else if (fall_evt_s && !run) begin
               time_clock_nxt_s = {TIME_WIDTH{1'b1}};
            end else if (fall_evt_s) begin
               time_clock_nxt_s = time_clock_r + TIME_WIDTH'(lo_use_s);
            end else begin
               time_clock_nxt_s = time_clock_r;
            end
         end
         STOPPED: begin
            if (run) begin
               time_clock_nxt_s = time_next + TIME_WIDTH'(lo_use_s);
            end else begin
               time_clock_nxt_s = {TIME_WIDTH{1'b1}};
            end
         end
         default: time_clock_nxt_s = time_clock_r;
      endcase
   end

   // Level, edge pulses, edge time and rise counter.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         level_r      <= 1'b0;
         time_clock_r <= TIME_WIDTH'(LO_INC_INIT);
         rise_r       <= 1'b0;
         fall_r       <= 1'b0;
         rise_cnt_r   <= {CNT_WIDTH{1'b0}};
      end else begin
         time_clock_r <= time_clock_nxt_s;
         rise_r       <= rise_evt_s;
         fall_r       <= fall_evt_s;
         if (rise_evt_s) begin
            level_r    <= 1'b1;
            rise_cnt_r <= rise_cnt_r + CNT_WIDTH'(1);
         end else if (fall_evt_s) begin
            level_r    <= 1'b0;
         end else begin
            level_r    <= level_r;
         end
      end
   end

   assign time_eq    = fire_s;
   assign time_clock = time_clock_r;
   assign clk_out    = {N{level_r}};
   assign rise       = rise_r;
   assign fall       = fall_r;
   assign rise_cnt   = rise_cnt_r;

endmodule

// File: tb/tb_prog_clock.sv
// -----------------------------------------------------------------------------
// tb_prog_clock
// Directed bench for prog_clock (HI_INC_INIT=3, LO_INC_INIT=2). The stimulus
// drives time_next cycle by cycle and queues each hand-computed edge; the
// monitor pops one entry per rise/fall pulse and checks level, next edge time
// and rise count.
// -----------------------------------------------------------------------------
module tb_prog_clock;

   localparam int TW = 32;
   localparam int IW = 16;
   localparam int CW = 32;

   logic          clk_sys = 1'b0;
   logic          rst_n;
   logic          run;
   logic [TW-1:0] time_next;
   logic [TW-1:0] time_clock;
   logic          time_eq;
   logic [0:0]    clk_out;
   logic          rise;
   logic          fall;
   logic [CW-1:0] rise_cnt;

   prog_clock_if #(.INC_WIDTH(IW)) cfg_if ();

   prog_clock #(
      .N(1), .TIME_WIDTH(TW), .INC_WIDTH(IW), .CNT_WIDTH(CW),
      .HI_INC_INIT(3), .LO_INC_INIT(2)
   ) dut (
      .clk_sys    (clk_sys),
      .rst_n      (rst_n),
      .time_next  (time_next),
      .time_clock (time_clock),
      .time_eq    (time_eq),
      .clk_out    (clk_out),
      .rise       (rise),
      .fall       (fall),
      .run        (run),
      .cfg        (cfg_if),
      .rise_cnt   (rise_cnt)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic          is_rise;
      logic [TW-1:0] tc;
      logic [CW-1:0] cnt;
   } edge_t;

   edge_t exp_q[$];
   int    total = 0;
   int    bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic r, input logic [TW-1:0] tc, input logic [CW-1:0] c);
      edge_t e;
      e.is_rise = r;
      e.tc      = tc;
      e.cnt     = c;
      exp_q.push_back(e);
   endtask

   // One system cycle with time_next = tn; time_eq is checked mid-cycle.
   task automatic tick(input logic [TW-1:0] tn, input logic exp_eq);
      time_next = tn;
      #1;
      check("time_eq", 64'(time_eq), 64'(exp_eq));
      @(posedge clk_sys);
      #1;
   endtask

   // Monitor: every edge pulse must match the next queued expectation.
   always @(negedge clk_sys) begin
      if (rst_n && (rise || fall)) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_edge: rise=%0d fall=%0d tc=%0h", rise, fall, time_clock);
         end else begin
            edge_t e;
            e = exp_q.pop_front();
            check("edge_rise",  64'(rise),       64'(e.is_rise));
            check("edge_fall",  64'(fall),       64'(!e.is_rise));
            check("edge_level", 64'(clk_out),    64'(e.is_rise));
            check("edge_time",  64'(time_clock), 64'(e.tc));
            check("edge_cnt",   64'(rise_cnt),   64'(e.cnt));
         end
      end
   end

   initial begin
      rst_n             = 1'b0;
      run               = 1'b1;
      time_next         = 32'd0;
      cfg_if.cfg_valid  = 1'b0;
      cfg_if.cfg_hi_inc = 16'd0;
      cfg_if.cfg_lo_inc = 16'd0;
      repeat (2) @(posedge clk_sys);
      #1;
      check("rst_level",  64'(clk_out),         64'd0);
      check("rst_time",   64'(time_clock),      64'd2);
      check("rst_ready",  64'(cfg_if.cfg_ready), 64'd1);
      check("rst_rise",   64'(rise),            64'd0);
      check("rst_fall",   64'(fall),            64'd0);
      check("rst_cnt",    64'(rise_cnt),        64'd0);
      check("rst_eq",     64'(time_eq),         64'd0);
      rst_n = 1'b1;

      // INIT 3/2: rise at 2, fall at 5, rise at 7
      tick(32'd0, 1'b0);
      tick(32'd1, 1'b0);
      push(1'b1, 32'd5, 32'd1);  tick(32'd2, 1'b1);
      tick(32'd3, 1'b0);
      tick(32'd4, 1'b0);
      push(1'b0, 32'd7, 32'd1);  tick(32'd5, 1'b1);
      push(1'b1, 32'd10, 32'd2); tick(32'd7, 1'b1);

      // Config 5/1 in the high phase: fall keeps old lo, next rise takes new hi
      cfg_if.cfg_valid = 1'b1; cfg_if.cfg_hi_inc = 16'd5; cfg_if.cfg_lo_inc = 16'd1;
      tick(32'd8, 1'b0);
      cfg_if.cfg_valid = 1'b0;
      check("ready_after_xfer", 64'(cfg_if.cfg_ready), 64'd0);
      push(1'b0, 32'd12, 32'd2); tick(32'd10, 1'b1);
      check("ready_pending", 64'(cfg_if.cfg_ready), 64'd0);
      push(1'b1, 32'd17, 32'd3); tick(32'd12, 1'b1);
      check("ready_after_apply", 64'(cfg_if.cfg_ready), 64'd1);
      push(1'b0, 32'd18, 32'd3); tick(32'd17, 1'b1);
      push(1'b1, 32'd23, 32'd4); tick(32'd18, 1'b1);
      push(1'b0, 32'd24, 32'd4); tick(32'd23, 1'b1);

      // Zero pair transferred in a rise cycle: that rise still steps by 5
      cfg_if.cfg_valid = 1'b1; cfg_if.cfg_hi_inc = 16'd0; cfg_if.cfg_lo_inc = 16'd0;
      push(1'b1, 32'd29, 32'd5); tick(32'd24, 1'b1);
      cfg_if.cfg_valid = 1'b0;
      check("ready_zero_xfer", 64'(cfg_if.cfg_ready), 64'd0);
      push(1'b0, 32'd30, 32'd5); tick(32'd29, 1'b1);
      push(1'b1, 32'd31, 32'd6); tick(32'd30, 1'b1);
      push(1'b0, 32'd32, 32'd6); tick(32'd31, 1'b1);
      push(1'b1, 32'd33, 32'd7); tick(32'd32, 1'b1);
      check("ready_zero_apply", 64'(cfg_if.cfg_ready), 64'd1);

      // Stop requested in the high phase: fall completes, then parked
      run = 1'b0;
      push(1'b0, 32'hFFFF_FFFF, 32'd7); tick(32'd33, 1'b1);
      check("stop_time",  64'(time_clock), 64'h0000_0000_FFFF_FFFF);
      check("stop_level", 64'(clk_out),    64'd0);
      tick(32'd34, 1'b0);
      tick(32'hFFFF_FFFF, 1'b0);

      // Pending 4/2 while stopped; restart near the top of the time range
      cfg_if.cfg_valid = 1'b1; cfg_if.cfg_hi_inc = 16'd4; cfg_if.cfg_lo_inc = 16'd2;
      tick(32'd35, 1'b0);
      cfg_if.cfg_valid = 1'b0;
      check("ready_stopped", 64'(cfg_if.cfg_ready), 64'd0);
      run = 1'b1;
      tick(32'hFFFF_FFFC, 1'b0);
      check("restart_time", 64'(time_clock), 64'h0000_0000_FFFF_FFFD);
      push(1'b1, 32'd1, 32'd8); tick(32'hFFFF_FFFD, 1'b1);
      check("ready_restart_apply", 64'(cfg_if.cfg_ready), 64'd1);
      push(1'b0, 32'd3, 32'd8); tick(32'd1, 1'b1);
      push(1'b1, 32'd7, 32'd9); tick(32'd3, 1'b1);

      // Reset with a pending config and the level high
      cfg_if.cfg_valid = 1'b1; cfg_if.cfg_hi_inc = 16'd9; cfg_if.cfg_lo_inc = 16'd9;
      tick(32'd4, 1'b0);
      cfg_if.cfg_valid = 1'b0;
      check("pre_rst_ready", 64'(cfg_if.cfg_ready), 64'd0);
      check("pre_rst_level", 64'(clk_out),          64'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_level", 64'(clk_out),          64'd0);
      check("mid_rst_time",  64'(time_clock),       64'd2);
      check("mid_rst_ready", 64'(cfg_if.cfg_ready), 64'd1);
      check("mid_rst_cnt",   64'(rise_cnt),         64'd0);
      @(posedge clk_sys);
      #1;
      rst_n = 1'b1;
      push(1'b1, 32'd5, 32'd1); tick(32'd2, 1'b1);
      push(1'b0, 32'd7, 32'd1); tick(32'd5, 1'b1);
      tick(32'd6, 1'b0);
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard time limit so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
